multi_osc: RTL



---
 rtl/multi_osc_pkg.sv | 7 +
 rtl/multi_osc_pipe.sv | 19 +
 rtl/multi_osc.sv | 55 +++++
 3 files changed

// File: rtl/multi_osc_pkg.sv
// multi_osc_pkg: synth-wide widths and oscillator mode/latency constants
package multi_osc_pkg;
  localparam int SYNTH_PHASE_ACC_BITS = 32;
  localparam int SYNTH_WIDTH = 16;
  localparam int OSC_DEFAULT_LATENCY = 3;
  typedef enum logic [1:0] {OSC_TRI, OSC_SAW, OSC_SQR, OSC_OFF} osc_mode_t;
endpackage

// File: rtl/multi_osc_pipe.sv
// multi_osc_pipe: DEPTH-stage delay line with synchronous active-low clear
module multi_osc_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);
  if (DEPTH == 0) begin : g_pass
    assign q_out = d_in;
  end else begin : g_pipe
    logic [DEPTH*WIDTH-1:0] sr_q, sr_d;
    always_comb sr_d = (sr_q << WIDTH) | (DEPTH*WIDTH)'(d_in);
    always_ff @(posedge clk_in) sr_q <= rst_in ? sr_d : '0;
    assign q_out = sr_q[DEPTH*WIDTH-1 -: WIDTH];
  end
endmodule

// File: rtl/multi_osc.sv
// multi_osc: phase-accumulator TRI/SAW/SQR/OFF oscillator with hard sync and wrap strobe
module multi_osc
  import multi_osc_pkg::*;
#(
  parameter int PHASE_BITS = SYNTH_PHASE_ACC_BITS,
  parameter int WIDTH = SYNTH_WIDTH,
  parameter int LATENCY = OSC_DEFAULT_LATENCY
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [PHASE_BITS-1:0]   phase_incr_in,
  input  osc_mode_t               mode_in,
  input  logic [WIDTH-1:0]        pw_in,
  input  logic                    sync_in,
  output logic signed [WIDTH-1:0] val_out,
  output logic                    wrap_out
);
  logic [PHASE_BITS:0] sum;
  logic [PHASE_BITS-1:0] acc_q, acc_d;
  logic wrap_q, wrap_d;
  osc_mode_t mode_q, mode_d;
  logic [WIDTH-1:0] pw_q, pw_d;
  logic [WIDTH-1:0] p, tri_w, saw_w, sqr_w, wave;
  logic [WIDTH-2:0] f;
  logic [WIDTH:0] out_q, out_d;
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, phase_incr_in};
    wrap_d = sum[PHASE_BITS] | sync_in;
    acc_d = sync_in ? '0 : sum[PHASE_BITS-1:0];
    mode_d = wrap_d ? mode_in : mode_q;
    pw_d = wrap_d ? pw_in : pw_q;
    p = acc_q[PHASE_BITS-1 -: WIDTH];
    f = p[WIDTH-1] ? ~p[WIDTH-2:0] : p[WIDTH-2:0];
    tri_w = {~f[WIDTH-2], f[WIDTH-3:0], 1'b0};
    saw_w = {~p[WIDTH-1], p[WIDTH-2:0]};
    sqr_w = (p < pw_q) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
    wave = mode_q == OSC_TRI ? tri_w : mode_q == OSC_SAW ? saw_w : mode_q == OSC_SQR ? sqr_w : '0;
  end
  // reset loads the live mode/pw so the first period already uses them
  always_ff @(posedge clk_in) begin
    acc_q <= rst_in ? acc_d : '0;
    wrap_q <= rst_in & wrap_d;
    mode_q <= rst_in ? mode_d : mode_in;
    pw_q <= rst_in ? pw_d : pw_in;
    out_q <= rst_in ? out_d : '0;
  end
  multi_osc_pipe #(.DEPTH(LATENCY-1), .WIDTH(WIDTH+1)) u_pipe (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .d_in  ({wrap_q, wave}),
    .q_out (out_d)
  );
  assign val_out = out_q[WIDTH-1:0];
  assign wrap_out = out_q[WIDTH];
endmodule
